// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, NOP instruction,
// register-index width and the load-use hazard predicate.
package riscv_pipe_pkg;

   localparam int unsigned REG_IDX_W = 5;

   // The all-zero word the IF/ID register loads when flushed.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } hz_state_t;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   function automatic logic load_use_hazard(
      input logic                 memread,
      input logic [REG_IDX_W-1:0] rd,
      input logic [REG_IDX_W-1:0] rs1,
      input logic [REG_IDX_W-1:0] rs2,
      input logic                 uses_rs2
   );
      return memread && (rd != '0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// 32-bit saturating event counter with increment enable.
module hazard_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / branch flush controller for the in-order pipeline.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned LOAD_STALL_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 id_ex_memread,
   input  logic [REG_IDX_W-1:0] id_ex_rd,
   input  logic [REG_IDX_W-1:0] if_id_rs1,
   input  logic [REG_IDX_W-1:0] if_id_rs2,
   input  logic                 if_id_uses_rs2,
   input  logic                 branch_taken,
   output logic                 pc_write,
   output logic                 if_id_write,
   output logic                 if_id_flush,
   output logic                 id_ex_bubble,
   output logic                 stall_active,
   output logic [31:0]          stall_cycles,
   output logic [31:0]          flush_events
);

   // The detection cycle is itself the first stall cycle, so STALL covers the rest.
   localparam logic [1:0] STALL_LOAD = 2'(LOAD_STALL_CYCLES - 1);

   hz_state_t  state;
   logic [1:0] cnt;
   logic       hz;

   assign hz = load_use_hazard(id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, if_id_uses_rs2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!branch_taken && hz && (LOAD_STALL_CYCLES > 1)) begin
                  state <= STALL;
                  cnt   <= STALL_LOAD;
               end
            end
            STALL: begin
               if (branch_taken || (cnt == 2'd1)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
         endcase
      end
   end

   // Gated by rst_n so outputs hold their safe values while reset is low.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      if (rst_n) begin
         if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if ((state == STALL) || hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   assign stall_active = rst_n && (state == STALL);

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_cnt u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~pc_write),
      .count (stall_cycles)
   );

   hazard_perf_cnt u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (if_id_flush),
      .count (flush_events)
   );
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table on the 1-cycle configuration
// plus sequences for multi-cycle stall, branch abort and reset mid-stall.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mr;
   logic [4:0]  rd, rs1, rs2;
   logic        u2, br;

   logic        pcw1, ifw1, fl1, bub1, sa1;
   logic [31:0] sc1, fe1;
   logic        pcw3, ifw3, fl3, bub3, sa3;
   logic [31:0] sc3, fe3;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_ex_memread(mr), .id_ex_rd(rd),
      .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(u2), .branch_taken(br),
      .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(fl1), .id_ex_bubble(bub1),
      .stall_active(sa1), .stall_cycles(sc1), .flush_events(fe1)
   );

   hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .id_ex_memread(mr), .id_ex_rd(rd),
      .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(u2), .branch_taken(br),
      .pc_write(pcw3), .if_id_write(ifw3), .if_id_flush(fl3), .id_ex_bubble(bub3),
      .stall_active(sa3), .stall_cycles(sc3), .flush_events(fe3)
   );

   typedef struct {
      logic       mr;
      logic [4:0] rd, rs1, rs2;
      logic       u2, br;
      logic       pcw, ifw, fl, bub;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic drive(input logic m, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic u, input logic b);
      @(negedge clk);
      mr = m; rd = d; rs1 = s1; rs2 = s2; u2 = u; br = b;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mr = 1'b0; rd = '0; rs1 = '0; rs2 = '0; u2 = 1'b0; br = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 5'd7,  5'd1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 5'd7,  5'd1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 5'd31, 5'd3, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 5'd4,  5'd5, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset state, with hazard and branch inputs active to prove the gating.
      rst_n = 1'b0;
      mr = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = '0; u2 = 1'b0; br = 1'b1;
      #2;
      chk("rst_pc_write",    32'(pcw1), 32'd1);
      chk("rst_if_id_write", 32'(ifw1), 32'd1);
      chk("rst_flush",       32'(fl1),  32'd0);
      chk("rst_bubble",      32'(bub1), 32'd0);
      chk("rst_stall_act",   32'(sa3),  32'd0);
      chk("rst_stall_cnt",   sc1,       32'd0);
      chk("rst_flush_cnt",   fe1,       32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].u2, vecs[i].br);
         chk($sformatf("vec%0d_pc_write", i),    32'(pcw1), 32'(vecs[i].pcw));
         chk($sformatf("vec%0d_if_id_write", i), 32'(ifw1), 32'(vecs[i].ifw));
         chk($sformatf("vec%0d_flush", i),       32'(fl1),  32'(vecs[i].fl));
         chk($sformatf("vec%0d_bubble", i),      32'(bub1), 32'(vecs[i].bub));
         chk($sformatf("vec%0d_stall_act", i),   32'(sa1),  32'd0);
      end

      // Single-cycle load-use stall; ID/EX holds a bubble on the next cycle.
      do_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      chk("ls1_c1_pc_write", 32'(pcw1), 32'd0);
      chk("ls1_c1_bubble",   32'(bub1), 32'd1);
      drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      chk("ls1_c2_pc_write", 32'(pcw1), 32'd1);
      chk("ls1_c2_bubble",   32'(bub1), 32'd0);
      chk("ls1_stall_cnt",   sc1, PERF ? 32'd1 : 32'd0);

      // Branch together with hazard: flush wins, no stall counted.
      do_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
      chk("brhz_flush",       32'(fl1),  32'd1);
      chk("brhz_bubble",      32'(bub1), 32'd1);
      chk("brhz_pc_write",    32'(pcw1), 32'd1);
      chk("brhz_if_id_write", 32'(ifw1), 32'd1);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("brhz_flush_cnt",   fe1, PERF ? 32'd1 : 32'd0);
      chk("brhz_stall_cnt",   sc1, 32'd0);

      // Three-cycle stall followed by a back-to-back hazard.
      do_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      chk("ls3_c1_pc_write",  32'(pcw3), 32'd0);
      chk("ls3_c1_stall_act", 32'(sa3),  32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("ls3_c2_pc_write",  32'(pcw3), 32'd0);
      chk("ls3_c2_stall_act", 32'(sa3),  32'd1);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("ls3_c3_pc_write",  32'(pcw3), 32'd0);
      chk("ls3_c3_bubble",    32'(bub3), 32'd1);
      chk("ls3_c3_stall_act", 32'(sa3),  32'd1);
      drive(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0);
      chk("ls3_c4_stall_act", 32'(sa3),  32'd0);
      chk("ls3_c4_stall_cnt", sc3, PERF ? 32'd3 : 32'd0);
      chk("ls3_c4_pc_write",  32'(pcw3), 32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("ls3_c5_stall_act", 32'(sa3),  32'd1);

      // Branch in the second stall cycle aborts the stall.
      do_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      chk("ab_c1_pc_write",  32'(pcw3), 32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      chk("ab_c2_flush",     32'(fl3),  32'd1);
      chk("ab_c2_bubble",    32'(bub3), 32'd1);
      chk("ab_c2_pc_write",  32'(pcw3), 32'd1);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("ab_c3_stall_act", 32'(sa3),  32'd0);
      chk("ab_c3_pc_write",  32'(pcw3), 32'd1);
      chk("ab_c3_flush",     32'(fl3),  32'd0);
      chk("ab_flush_cnt",    fe3, PERF ? 32'd1 : 32'd0);

      // Reset dropped mid-stall takes effect before the next rising edge.
      do_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("rs_pre_stall_act", 32'(sa3),  32'd1);
      chk("rs_pre_pc_write",  32'(pcw3), 32'd0);
      chk("rs_pre_stall_cnt", sc3, PERF ? 32'd1 : 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("rs_pc_write",   32'(pcw3), 32'd1);
      chk("rs_stall_act",  32'(sa3),  32'd0);
      chk("rs_stall_cnt",  sc3,       32'd0);
      chk("rs_flush_cnt",  fe3,       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("rs_post_pc_write", 32'(pcw3), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter LOAD_STALL_CYCLES, default 1, giving the number of stall cycles per load-use hazard (legal range 1..3).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port id_ex_memread, input, 1 bit: the ID/EX-stage instruction is a load.
REQ-005 The block SHALL have port id_ex_rd, input, 5 bits: destination register of the ID/EX-stage instruction.
REQ-006 The block SHALL have ports if_id_rs1 and if_id_rs2, input, 5 bits each: source registers of the IF/ID-stage instruction.
REQ-007 The block SHALL have port if_id_uses_rs2, input, 1 bit: the IF/ID-stage instruction reads rs2.
REQ-008 The block SHALL have port branch_taken, input, 1 bit: the EX stage resolved a taken branch this cycle.
REQ-009 The block SHALL have port pc_write, output, 1 bit: 1 = PC may update.
REQ-010 The block SHALL have port if_id_write, output, 1 bit: 1 = IF/ID register may load.
REQ-011 The block SHALL have port if_id_flush, output, 1 bit: 1 = IF/ID loads a NOP (all-zero instruction).
REQ-012 The block SHALL have port id_ex_bubble, output, 1 bit: 1 = ID/EX loads all-zero controls (MemtoReg, regwrite, branch, MemRead, MemWrite, alu_src, alu_op).
REQ-013 The block SHALL have port stall_active, output, 1 bit: FSM is in STALL.
REQ-014 The block SHALL have ports stall_cycles and flush_events, output, 32 bits each: performance counters.

Function
REQ-015 The block SHALL detect a load-use hazard (hz) when id_ex_memread=1, id_ex_rd!=0, and either id_ex_rd==if_id_rs1 or (if_id_uses_rs2=1 and id_ex_rd==if_id_rs2).
REQ-016 The block SHALL implement FSM states IDLE and STALL, with a 2-bit down-counter cnt.
REQ-017 The block SHALL, in IDLE with branch_taken=1, drive if_id_flush=1, id_ex_bubble=1, pc_write=1 and if_id_write=1 combinationally in the same cycle, and remain in IDLE (branch beats hz).
REQ-018 The block SHALL, in IDLE with branch_taken=0 and hz=1, drive pc_write=0, if_id_write=0 and id_ex_bubble=1 in the same cycle; if LOAD_STALL_CYCLES>1 it SHALL go to STALL with cnt=LOAD_STALL_CYCLES-1, else it SHALL stay in IDLE.
REQ-019 The block SHALL, in IDLE with neither condition, drive pc_write=1, if_id_write=1, if_id_flush=0 and id_ex_bubble=0.
REQ-020 The block SHALL, in STALL, drive pc_write=0, if_id_write=0 and id_ex_bubble=1, decrement cnt each cycle, and return to IDLE on the edge where cnt==1.
REQ-021 The block SHALL, on branch_taken=1 in STALL, apply the REQ-017 outputs and go to IDLE on the next edge (abort the stall).
REQ-022 The block SHALL re-evaluate hz in the cycle after a stall completes; back-to-back hazards each produce a full stall.
REQ-023 The block SHALL keep all outputs combinational from state and inputs except the counters, which SHALL be registered.

Reset
REQ-024 The block SHALL, while rst_n=0, force state=IDLE, cnt=0 and counters=0, and drive pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0 and stall_active=0.
REQ-025 The block SHALL, on reset asserted mid-STALL, abandon the stall immediately without waiting for a clock edge.

Configuration
REQ-026 The block SHALL, with macro HAZARD_PERF_CNT_EN defined, increment stall_cycles on each cycle with pc_write=0 and flush_events on each cycle with if_id_flush=1, both saturating at 32'hFFFF_FFFF.
REQ-027 The block SHALL, without HAZARD_PERF_CNT_EN, still present stall_cycles and flush_events but drive them to constant 0 and instantiate no counter flops.

Structure
REQ-028 The block SHALL take its FSM state typedef (IDLE=0, STALL=1), the NOP instruction constant and the register-index width (5) from shared package riscv_pipe_pkg.
REQ-029 The block SHALL implement each counter as an instance of sub-module hazard_perf_cnt (32-bit saturating, with increment enable).

Verification
REQ-030 The bench SHALL check: id_ex_memread=1, id_ex_rd=5, if_id_rs1=5 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle, then pc_write=1.
REQ-031 The bench SHALL check: id_ex_memread=1, id_ex_rd=0, if_id_rs1=0 -> no stall, pc_write=1.
REQ-032 The bench SHALL check: id_ex_rd=7, if_id_rs2=7, if_id_uses_rs2=0 -> no stall; same stimulus with if_id_uses_rs2=1 -> 1-cycle stall.
REQ-033 The bench SHALL check: branch_taken=1 together with hz=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1, and flush_events becomes 1.
REQ-034 The bench SHALL check: with LOAD_STALL_CYCLES=3, a hazard gives 3 stall cycles and stall_cycles=3; branch_taken raised in the 2nd stall cycle -> flush, then IDLE.
REQ-035 The bench SHALL check: rst_n dropped mid-STALL (LOAD_STALL_CYCLES=3) -> pc_write=1, stall_active=0 and counters=0 before the next clock edge.
